// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, FSM states
// and fault cause values.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_ILLEGAL    = 2'd2,
        CAUSE_TIMEOUT    = 2'd3
    } fault_cause_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane replication and byte enables,
// load extraction with sign/zero extension, and access legality.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic        illegal,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be         = '0;
        wdata      = store_data;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (is_write) begin
            case (funct3)
                F3_B: begin
                    be    = 4'b0001 << lane;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be    = lane[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data[15:0]}};
                end
                F3_W:    be = '1;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU, F3_H, F3_HU, F3_W: illegal = 1'b0;
                default:                        illegal = 1'b1;
            endcase
        end
        // funct3[1:0] encodes the access size for every legal code
        if (funct3[1:0] == 2'b01 && lane[0])
            misaligned = 1'b1;
        if (funct3[1:0] == 2'b10 && lane != 2'b00)
            misaligned = 1'b1;
    end

    always_comb begin
        shifted  = bus_rdata >> {ld_lane, 3'b000};
        ld_byte  = shifted[7:0];
        ld_half  = ld_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (ld_funct3)
            F3_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_ext = {24'd0, ld_byte};
            F3_H:    load_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_ext = {16'd0, ld_half};
            default: load_ext = bus_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues aligned bus transactions for core loads/stores,
// stalls the core until completion and reports faults in the DONE cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_lane_q;
    logic        req;
    logic [3:0]  be_al;
    logic [31:0] wdata_al;
    logic [31:0] load_ext;
    logic        illegal;
    logic        misaligned;

    assign req   = mem_read | mem_write;
    assign stall = req && (state != S_DONE);

    // mem_write alone selects the direction, so a read+write request is a write
    lsu_align u_align (
        .is_write   (mem_write),
        .funct3     (funct3),
        .lane       (addr[1:0]),
        .store_data (store_data),
        .ld_funct3  (ld_f3_q),
        .ld_lane    (ld_lane_q),
        .bus_rdata  (bus_rdata),
        .be         (be_al),
        .wdata      (wdata_al),
        .load_ext   (load_ext),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            ld_f3_q     <= '0;
            ld_lane_q   <= '0;
            load_data   <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ILLEGAL;
                            state       <= S_DONE;
                        end else if (misaligned) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGNED;
                            state       <= S_DONE;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= wdata_al;
                            bus_be    <= mem_write ? be_al : 4'b0000;
                            ld_f3_q   <= funct3;
                            ld_lane_q <= addr[1:0];
                            wait_cnt  <= '0;
                            state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            load_data <= load_ext;
                        state <= S_DONE;
                    end else if (wait_cnt == TO_LAST) begin
                        bus_req     <= 1'b0;
                        load_data   <= '0;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    fault       <= 1'b0;
                    fault_cause <= CAUSE_NONE;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, hand sequences for
// reset/late-ack corner cases, and randomized accesses against a spec model.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, fault;
    logic [1:0]  fault_cause;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_ld;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .stall(stall), .fault(fault),
        .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [1:0]  cause;
        logic        chk_ld;
        logic [31:0] ld;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] baddr;
        int          req_cycles;
        int          stall_cycles;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        int unsigned dly;
        exp_t        e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: legality, byte lanes and extension from plain arithmetic.
    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] sd,
                                   input logic [31:0] rdata, input int unsigned dly,
                                   input logic [31:0] ld_prev);
        exp_t e;
        int size;
        int off;
        bit legal;
        longint unsigned mask, val;
        e = '{fault: 1'b0, cause: 2'd0, chk_ld: 1'b1, ld: ld_prev, we: wr,
              be: 4'h0, wdata: 32'h0, baddr: a & 32'hFFFF_FFFC,
              req_cycles: 0, stall_cycles: 1};
        size = 1 << (int'(f3) % 4);
        off  = int'(a % 4);
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal || (off % size) != 0) begin
            e.fault  = 1'b1;
            e.cause  = legal ? 2'd1 : 2'd2;
            e.chk_ld = 1'b0;
            return e;
        end
        if (wr) begin
            e.be = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++)
                e.wdata[8*i +: 8] = 8'(sd >> (8 * (i % size)));
        end
        if (dly >= TO) begin
            e.fault = 1'b1;
            e.cause = 2'd3;
            e.ld = 32'h0;
            e.req_cycles = int'(TO);
            e.stall_cycles = int'(TO) + 1;
            return e;
        end
        e.req_cycles = int'(dly) + 1;
        e.stall_cycles = int'(dly) + 2;
        if (!wr) begin
            mask = (64'd1 << (8 * size)) - 1;
            val  = (longint'(rdata) >> (8 * off)) & mask;
            if (f3 < 3'd4 && size < 4 && val[8*size-1])
                val = val | ~mask;
            e.ld = val[31:0];
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdata, input int unsigned dly,
                              input exp_t e);
        int  reqc = 0;
        int  stc = 0;
        bit  done = 0;
        bit  stable_ok = 1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                chk("fault", 32'(fault), 32'(e.fault));
                chk("fault_cause", 32'(fault_cause), 32'(e.cause));
                if (e.chk_ld) begin
                    chk("load_data", load_data, e.ld);
                    last_ld = e.ld;
                end
                chk("stall_cycles", stc, e.stall_cycles);
                chk("req_cycles", reqc, e.req_cycles);
                chk("req_in_done", 32'(bus_req), 32'd0);
            end else begin
                stc++;
                if (fault) stable_ok = 0;
                if (bus_req) begin
                    if (reqc == 0) begin
                        chk("bus_addr", bus_addr, e.baddr);
                        chk("bus_we", 32'(bus_we), 32'(e.we));
                        chk("bus_be", 32'(bus_be), 32'(e.be));
                        if (wr) chk("bus_wdata", bus_wdata, e.wdata);
                    end else if (bus_addr !== e.baddr || bus_we !== e.we || bus_be !== e.be)
                        stable_ok = 0;
                    reqc++;
                    if (reqc - 1 == int'(dly)) begin
                        bus_ack = 1'b1;
                        bus_rdata = rdata;
                    end
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL access_hang actual=stalled required=done");
        end
        chk("bus_stable", 32'(stable_ok), 32'd1);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    vec_t vt[14];

    initial begin
        exp_t e;
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] a, sd, rdv;
        int unsigned dly;
        bit seen;

        vt[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 0,
                   '{1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h11223344, 32'h100, 1, 2}};
        vt[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0,
                   '{1'b0, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0, 32'h100, 1, 2}};
        vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0,
                   '{1'b0, 2'd0, 1'b1, 32'h00000080, 1'b0, 4'h0, 32'h0, 32'h100, 1, 2}};
        vt[3]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 0,
                   '{1'b0, 2'd0, 1'b1, 32'hFFFF80FF, 1'b0, 4'h0, 32'h0, 32'h100, 1, 2}};
        vt[4]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0,
                   '{1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 4'hC, 32'hABCDABCD, 32'h100, 1, 2}};
        vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0,
                   '{1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h100, 0, 1}};
        vt[6]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0,
                   '{1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h100, 0, 1}};
        vt[7]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 2,
                   '{1'b0, 2'd0, 1'b1, 32'h0000F00D, 1'b0, 4'h0, 32'h0, 32'h100, 3, 4}};
        vt[8]  = '{1'b1, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0,
                   '{1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 4'h2, 32'hA5A5A5A5, 32'h100, 1, 2}};
        vt[9]  = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0,
                   '{1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h100, 0, 1}};
        vt[10] = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 0,
                   '{1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h100, 0, 1}};
        vt[11] = '{1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'hDEADBEEF, 3,
                   '{1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 32'h204, 4, 5}};
        vt[12] = '{1'b0, 1'b1, 3'b010, 32'h300, 32'h01020304, 32'h0, 99,
                   '{1'b1, 2'd3, 1'b1, 32'h0, 1'b1, 4'hF, 32'h01020304, 32'h300, 4, 5}};
        vt[13] = '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 99,
                   '{1'b1, 2'd3, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h200, 4, 5}};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; store_data = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_cause", 32'(fault_cause), 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_ld = 32'h0;

        foreach (vt[i])
            run_access(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].sd,
                       vt[i].rdata, vt[i].dly, vt[i].e);

        // late ack while idle must be ignored
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(bus_req), 32'h0);
        chk("late_ack_fault", 32'(fault), 32'h0);
        chk("late_ack_ld", load_data, last_ld);
        chk("late_ack_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;

        // reset while in WAIT with the load still held
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus_req) seen = 1;
        end
        chk("rw_reached_wait", 32'(seen), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rw_req_dropped", 32'(bus_req), 32'h0);
        chk("rw_addr_cleared", bus_addr, 32'h0);
        chk("rw_ld_cleared", load_data, 32'h0);
        chk("rw_stall", 32'(stall), 32'h1);
        @(negedge clk);
        chk("rw_req_again", 32'(bus_req), 32'h1);
        chk("rw_addr_again", bus_addr, 32'h400);
        bus_ack = 1'b1; bus_rdata = 32'h55AA00FF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rw_done_stall", 32'(stall), 32'h0);
        chk("rw_done_ld", load_data, 32'h55AA00FF);
        last_ld = 32'h55AA00FF;
        @(posedge clk); #1;
        mem_read = 1'b0;

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            sd  = $urandom;
            rdv = $urandom;
            dly = $urandom_range(0, 5);
            e = model(rd, wr, f3, a, sd, rdv, dly, last_ld);
            run_access(rd, wr, f3, a, sd, rdv, dly, e);
            if (n % 10 == 0) begin
                @(negedge clk);
                chk("idle_stall", 32'(stall), 32'h0);
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
